data_check: RTL and testbench
=============================

DATA_CHECK -- requirements
Module: data_check

Interface
REQ-001 Parameter: DW, default 512, AXI-Stream data width in bits; multiple of 16.
REQ-002 Parameter: BEATS_PER_PKT, default 4, expected beats per packet; tlast is expected on the last beat.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle pulse; clears all results and arms a check run.
REQ-006 Port: max_cycles  input  32  number of beats to accept per run; sampled on start.
REQ-007 Port: throttle  input  4  idle cycles with tready low after each accepted beat; sampled on start.
REQ-008 Port: axis_tdata  input  DW  stream data; expected value is a 16-bit counter replicated DW/16 times.
REQ-009 Port: axis_tvalid  input  1  stream valid.
REQ-010 Port: axis_tlast  input  1  stream packet end.
REQ-011 Port: axis_tready  output  1  stream ready (backpressure).
REQ-012 Port: beats_rcvd  output  32  count of accepted beats this run.
REQ-013 Port: data_errors  output  32  count of beats whose tdata mismatches the expected pattern.
REQ-014 Port: last_errors  output  32  count of beats whose tlast disagrees with the expected packet position.
REQ-015 Port: first_err_beat  output  32  beat index (0-based) of the first data or tlast error; 0xFFFFFFFF if none.
REQ-016 Port: first_err_data  output  16  tdata[15:0] captured at the first data error; 0 if none.
REQ-017 Port: done  output  1  high while in DONE.
REQ-018 Port: pass  output  1  high in DONE when data_errors==0 and last_errors==0; else low.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DONE; xfer = axis_tvalid & axis_tready.
REQ-020 IDLE: axis_tready=0; start -> RUN.
REQ-021 On start (any state): counters=0, expected=0x0000, beat_in_pkt=0, throttle_cnt=0, first_err_beat=0xFFFFFFFF, first_err_data=0; if max_cycles==0 next state is DONE, else RUN.
REQ-022 RUN: axis_tready=1 when throttle_cnt==0; on xfer throttle_cnt loads the latched throttle value and then decrements once per cycle to 0.
REQ-023 On xfer, tdata SHALL be compared against {DW/16{expected}}; a mismatch increments data_errors.
REQ-024 On xfer, expected tlast = (beat_in_pkt==BEATS_PER_PKT-1); a mismatch increments last_errors.
REQ-025 After xfer, expected SHALL become tdata[15:0]+1 mod 2^16 (resync), so one corrupted beat yields one error; 0xFFFF wraps to 0x0000.
REQ-026 beat_in_pkt SHALL clear to 0 on xfer with received tlast=1, else increment, wrapping to 0 after BEATS_PER_PKT-1.
REQ-027 first_err_beat/first_err_data SHALL capture on the first error only; a simultaneous data and tlast error counts in both counters.
REQ-028 All 32-bit counters SHALL saturate at 0xFFFFFFFF.
REQ-029 On xfer where beats_rcvd+1 == max_cycles: RUN -> DONE; tready=0 from the next cycle.
REQ-030 DONE: axis_tready=0; outputs hold; start re-arms per REQ-021; start in RUN restarts identically.
REQ-031 Result outputs SHALL be registered and reflect an xfer one cycle after it.

Reset
REQ-032 reset SHALL force IDLE, axis_tready=0, all counters 0, first_err_beat=0xFFFFFFFF, first_err_data=0, done=0, pass=0; reset dominates start.
REQ-033 reset mid-RUN SHALL abandon the run with no further beats accepted.

Structure
REQ-034 A shared package data_stream_pkg SHALL hold PATTERN_W=16, default DW, default BEATS_PER_PKT and the FSM state enum; shared with the stream generator.
REQ-035 The replicated-pattern comparator SHALL be a sub-module data_check_cmp (combinational, DW/16 lanes, single mismatch output).

Verification
REQ-036 Clean stream 0..11, tlast every 4th, max_cycles=12, throttle=0 -> tready continuous, done after 12th beat, beats_rcvd=12, pass=1.
REQ-037 Beat 5 lane 7 corrupted to 0xBEEF -> data_errors=1, first_err_beat=5, first_err_data=0x0005 (lane 0), later beats clean, pass=0.
REQ-038 tlast missing on beat 3, present on beat 4 -> last_errors=2, first_err_beat=3.
REQ-039 throttle=3, source always valid, max_cycles=8 -> tready pattern 1,0,0,0 repeating; 8 beats in 29 cycles.
REQ-040 Stream starts at 0xFFFE, max_cycles=4 -> first beat error (expected 0), resync; 0xFFFF->0x0000 wrap clean; data_errors=1.
REQ-041 reset asserted after beat 2, then start with max_cycles=0 -> IDLE, counters 0; next cycle DONE, pass=1, no beats accepted.

Source files
------------

// File: rtl/data_stream_pkg.sv
// -----------------------------------------------------------------------------
// data_stream_pkg
// Shared definitions for the counter-pattern AXI-Stream generator and checker.
//   PATTERN_W              width of the repeating counter word carried per lane
//   DEFAULT_DW             default stream data width (multiple of PATTERN_W)
//   DEFAULT_BEATS_PER_PKT  default packet length in beats (tlast on last beat)
//   CNT_MAX                saturation value of all 32-bit result counters
//   state_e                checker run-control state
//   sat_inc()              saturating 32-bit increment
// -----------------------------------------------------------------------------
package data_stream_pkg;

  localparam int PATTERN_W             = 16;
  localparam int DEFAULT_DW            = 512;
  localparam int DEFAULT_BEATS_PER_PKT = 4;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Increment that sticks at CNT_MAX instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    logic [31:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_check_cmp.sv
// -----------------------------------------------------------------------------
// data_check_cmp
// Combinational comparator: checks every PATTERN_W-bit lane of a stream word
// against one expected counter value.
//   i_data      stream data word, DW bits (DW/PATTERN_W lanes)
//   i_pattern   expected counter value for every lane
//   o_mismatch  high when any lane differs from i_pattern
// -----------------------------------------------------------------------------
module data_check_cmp
  import data_stream_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic [DW-1:0]        i_data,
  input  logic [PATTERN_W-1:0] i_pattern,
  output logic                 o_mismatch
);

  localparam int LANES = DW / PATTERN_W;

  logic [LANES-1:0] w_lane_mis;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_mis[l] = (i_data[l*PATTERN_W +: PATTERN_W] != i_pattern);
  end

  // A single bad lane marks the whole beat as one data error.
  assign o_mismatch = |w_lane_mis;

endmodule

// File: rtl/data_check.sv
// -----------------------------------------------------------------------------
// data_check
// AXI-Stream sink that checks a replicated 16-bit counter pattern and packet
// framing, with optional throttling, and reports registered results.
//   clk             single clock, rising edge
//   reset           synchronous active-high reset (dominates start)
//   start           one-cycle pulse: clear results and arm a run
//   max_cycles      beats to accept per run (sampled on start; 0 = finish now)
//   throttle        idle cycles with tready low after each beat (sampled on start)
//   axis_tdata      stream data, DW bits
//   axis_tvalid     stream valid
//   axis_tlast      stream packet end
//   axis_tready     stream ready (registered)
//   beats_rcvd      accepted beats this run (saturating)
//   data_errors     beats with a pattern mismatch (saturating)
//   last_errors     beats with tlast at the wrong packet position (saturating)
//   first_err_beat  0-based beat index of first error, 0xFFFFFFFF if none
//   first_err_data  tdata[15:0] of the first data error, 0 if none
//   done            high in DONE
//   pass            high in DONE when no data or tlast errors were seen
// -----------------------------------------------------------------------------
module data_check
  import data_stream_pkg::*;
#(
  parameter int DW            = DEFAULT_DW,
  parameter int BEATS_PER_PKT = DEFAULT_BEATS_PER_PKT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   max_cycles,
  input  logic [3:0]    throttle,
  input  logic [DW-1:0] axis_tdata,
  input  logic          axis_tvalid,
  input  logic          axis_tlast,
  output logic          axis_tready,
  output logic [31:0]   beats_rcvd,
  output logic [31:0]   data_errors,
  output logic [31:0]   last_errors,
  output logic [31:0]   first_err_beat,
  output logic [15:0]   first_err_data,
  output logic          done,
  output logic          pass
);

  localparam logic [31:0] LAST_POS = 32'(BEATS_PER_PKT - 1);

  state_e                r_state;
  logic [31:0]           r_max_cycles;
  logic [3:0]            r_throttle;
  logic [3:0]            r_thr_cnt;
  logic [PATTERN_W-1:0]  r_expected;
  logic [31:0]           r_beat_in_pkt;
  logic [31:0]           r_beats;
  logic [31:0]           r_data_errors;
  logic [31:0]           r_last_errors;
  logic [31:0]           r_first_err_beat;
  logic [15:0]           r_first_err_data;
  logic                  r_err_seen;
  logic                  r_data_err_seen;
  logic                  r_tready;
  logic                  r_done;
  logic                  r_pass;

  logic                  w_xfer;
  logic                  w_data_err;
  logic                  w_last_exp;
  logic                  w_last_err;
  logic                  w_final;
  logic                  w_pass_nxt;

  data_check_cmp #(
    .DW (DW)
  ) u_cmp (
    .i_data     (axis_tdata),
    .i_pattern  (r_expected),
    .o_mismatch (w_data_err)
  );

  // r_tready is only ever high in RUN, so a handshake implies RUN.
  assign w_xfer     = axis_tvalid & r_tready;
  assign w_last_exp = (r_beat_in_pkt == LAST_POS);
  assign w_last_err = axis_tlast ^ w_last_exp;
  // 33-bit compare so a saturated beat counter can never alias max_cycles.
  assign w_final    = (({1'b0, r_beats} + 33'd1) == {1'b0, r_max_cycles});
  // Verdict including the beat being accepted on the finishing cycle.
  assign w_pass_nxt = (r_data_errors == 32'd0) && !w_data_err &&
                      (r_last_errors == 32'd0) && !w_last_err;

  // Run-control FSM with all result registers and the registered tready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_max_cycles     <= 32'd0;
      r_throttle       <= 4'd0;
      r_thr_cnt        <= 4'd0;
      r_expected       <= 16'h0000;
      r_beat_in_pkt    <= 32'd0;
      r_beats          <= 32'd0;
      r_data_errors    <= 32'd0;
      r_last_errors    <= 32'd0;
      r_first_err_beat <= CNT_MAX;
      r_first_err_data <= 16'h0000;
      r_err_seen       <= 1'b0;
      r_data_err_seen  <= 1'b0;
      r_tready         <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else if (start) begin
      // Start clears everything from any state, including mid-run.
      r_max_cycles     <= max_cycles;
      r_throttle       <= throttle;
      r_thr_cnt        <= 4'd0;
      r_expected       <= 16'h0000;
      r_beat_in_pkt    <= 32'd0;
      r_beats          <= 32'd0;
      r_data_errors    <= 32'd0;
      r_last_errors    <= 32'd0;
      r_first_err_beat <= CNT_MAX;
      r_first_err_data <= 16'h0000;
      r_err_seen       <= 1'b0;
      r_data_err_seen  <= 1'b0;
      if (max_cycles == 32'd0) begin
        r_state  <= ST_DONE;
        r_tready <= 1'b0;
        r_done   <= 1'b1;
        r_pass   <= 1'b1;
      end else begin
        r_state  <= ST_RUN;
        r_tready <= 1'b1;
        r_done   <= 1'b0;
        r_pass   <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tready <= 1'b0;
          r_done   <= 1'b0;
          r_pass   <= 1'b0;
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_beats <= sat_inc(r_beats);
            if (w_data_err) begin
              r_data_errors <= sat_inc(r_data_errors);
            end
            if (w_last_err) begin
              r_last_errors <= sat_inc(r_last_errors);
            end
            if ((w_data_err || w_last_err) && !r_err_seen) begin
              r_err_seen       <= 1'b1;
              r_first_err_beat <= r_beats;
            end
            if (w_data_err && !r_data_err_seen) begin
              r_data_err_seen  <= 1'b1;
              r_first_err_data <= axis_tdata[15:0];
            end
            // Resync to the received word so one bad beat costs one error.
            r_expected <= axis_tdata[PATTERN_W-1:0] + 16'd1;
            // Received tlast re-frames the packet; otherwise count and wrap.
            if (axis_tlast || w_last_exp) begin
              r_beat_in_pkt <= 32'd0;
            end else begin
              r_beat_in_pkt <= r_beat_in_pkt + 32'd1;
            end
            if (w_final) begin
              r_state   <= ST_DONE;
              r_thr_cnt <= 4'd0;
              r_tready  <= 1'b0;
              r_done    <= 1'b1;
              r_pass    <= w_pass_nxt;
            end else begin
              r_thr_cnt <= r_throttle;
              r_tready  <= (r_throttle == 4'd0);
            end
          end else if (r_thr_cnt != 4'd0) begin
            // tready rises on the cycle the idle count reaches zero.
            r_thr_cnt <= r_thr_cnt - 4'd1;
            r_tready  <= (r_thr_cnt == 4'd1);
          end else begin
            r_tready <= 1'b1;
          end
        end
        ST_DONE: begin
          r_tready <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_tready <= 1'b0;
          r_done   <= 1'b0;
          r_pass   <= 1'b0;
        end
      endcase
    end
  end

  assign axis_tready    = r_tready;
  assign beats_rcvd     = r_beats;
  assign data_errors    = r_data_errors;
  assign last_errors    = r_last_errors;
  assign first_err_beat = r_first_err_beat;
  assign first_err_data = r_first_err_data;
  assign done           = r_done;
  assign pass           = r_pass;

endmodule

// File: tb/tb_data_check.sv
// -----------------------------------------------------------------------------
// tb_data_check
// Directed bench for data_check: a small behavioural model pushes expected
// results per accepted beat into a scoreboard queue; they are popped and
// compared one cycle later. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_data_check;

  localparam int DW    = 512;
  localparam int BPP   = 4;
  localparam int LANES = DW / 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   max_cycles;
  logic [3:0]    throttle;
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tlast;
  logic          axis_tready;
  logic [31:0]   beats_rcvd;
  logic [31:0]   data_errors;
  logic [31:0]   last_errors;
  logic [31:0]   first_err_beat;
  logic [15:0]   first_err_data;
  logic          done;
  logic          pass;

  data_check #(
    .DW            (DW),
    .BEATS_PER_PKT (BPP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .max_cycles     (max_cycles),
    .throttle       (throttle),
    .axis_tdata     (axis_tdata),
    .axis_tvalid    (axis_tvalid),
    .axis_tlast     (axis_tlast),
    .axis_tready    (axis_tready),
    .beats_rcvd     (beats_rcvd),
    .data_errors    (data_errors),
    .last_errors    (last_errors),
    .first_err_beat (first_err_beat),
    .first_err_data (first_err_data),
    .done           (done),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] beats;
    logic [31:0] derr;
    logic [31:0] lerr;
    logic [31:0] feb;
    logic [15:0] fed;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] dat [0:15];
  logic        lst [0:15];
  int          corr_beat = -1;
  int          corr_lane = 0;
  logic [15:0] corr_val  = 16'h0000;
  int          run_cycles;

  function automatic logic [DW-1:0] beat_data(input int k);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*16 +: 16] = dat[k];
    if (k == corr_beat) v[corr_lane*16 +: 16] = corr_val;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic do_start(input logic [31:0] maxc, input logic [3:0] thr);
    @(negedge clk);
    start      = 1'b1;
    max_cycles = maxc;
    throttle   = thr;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic set_clean(input int n);
    corr_beat = -1;
    for (int i = 0; i < 16; i++) begin
      dat[i] = 16'(i);
      lst[i] = ((i % BPP) == (BPP - 1));
    end
    if (n > 16) $error("FAIL set_clean: stream length %0d exceeds table", n);
  endtask

  // Runs one check; abort_after >= 0 stops driving after that many beats.
  task automatic run(input logic [31:0] maxc, input logic [3:0] thr, input int abort_after);
    logic [15:0]   m_exp   = 16'h0000;
    int            m_bip   = 0;
    logic [31:0]   m_beats = 32'd0;
    logic [31:0]   m_derr  = 32'd0;
    logic [31:0]   m_lerr  = 32'd0;
    logic [31:0]   m_feb   = 32'hFFFF_FFFF;
    logic [15:0]   m_fed   = 16'h0000;
    bit            seen    = 1'b0;
    bit            dseen   = 1'b0;
    logic [3:0]    m_thr   = 4'd0;
    bit            m_run;
    int            k       = 0;
    int            guard   = 0;
    int            c_first = -1;
    int            c_last  = -1;
    logic [DW-1:0] td;
    bit            de, le, exl;
    exp_t          e;
    sb.delete();
    do_start(maxc, thr);
    m_run = (maxc != 32'd0);
    forever begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("beats_rcvd", beats_rcvd, e.beats);
        chk("data_errors", data_errors, e.derr);
        chk("last_errors", last_errors, e.lerr);
        chk("first_err_beat", first_err_beat, e.feb);
        chk("first_err_data", 32'(first_err_data), 32'(e.fed));
      end
      chk("axis_tready", 32'(axis_tready), 32'(m_run && (m_thr == 4'd0)));
      if (!m_run || (abort_after >= 0 && k == abort_after)) break;
      if (guard >= 1000 || k >= 16) begin
        n_vec++;
        n_err++;
        $error("FAIL run_bound: observed %0d cycles %0d beats, required completion", guard, k);
        break;
      end
      td          = beat_data(k);
      axis_tdata  = td;
      axis_tlast  = lst[k];
      axis_tvalid = 1'b1;
      if (m_thr == 4'd0) begin
        de  = (td != {LANES{m_exp}});
        exl = (m_bip == BPP - 1);
        le  = (lst[k] != exl);
        if (de) m_derr++;
        if (le) m_lerr++;
        if ((de || le) && !seen) begin
          seen  = 1'b1;
          m_feb = m_beats;
        end
        if (de && !dseen) begin
          dseen = 1'b1;
          m_fed = td[15:0];
        end
        m_exp = td[15:0] + 16'd1;
        m_bip = (lst[k] || exl) ? 0 : m_bip + 1;
        m_beats++;
        sb.push_back('{m_beats, m_derr, m_lerr, m_feb, m_fed});
        if (c_first < 0) c_first = guard;
        c_last = guard;
        k++;
        m_thr = thr;
        if (m_beats == maxc) m_run = 1'b0;
      end else begin
        m_thr--;
      end
      @(negedge clk);
      guard++;
    end
    run_cycles = (c_first < 0) ? 0 : (c_last - c_first + 1);
  endtask

  task automatic final_check(input logic [31:0] beats, input logic [31:0] derr,
                             input logic [31:0] lerr, input logic [31:0] feb,
                             input logic [15:0] fed, input logic exp_pass);
    chk("end_beats_rcvd", beats_rcvd, beats);
    chk("end_data_errors", data_errors, derr);
    chk("end_last_errors", last_errors, lerr);
    chk("end_first_err_beat", first_err_beat, feb);
    chk("end_first_err_data", 32'(first_err_data), 32'(fed));
    chk("end_done", 32'(done), 32'd1);
    chk("end_pass", 32'(pass), 32'(exp_pass));
    chk("end_tready", 32'(axis_tready), 32'd0);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_tready"}, 32'(axis_tready), 32'd0);
    chk({tag, "_beats"}, beats_rcvd, 32'd0);
    chk({tag, "_derr"}, data_errors, 32'd0);
    chk({tag, "_lerr"}, last_errors, 32'd0);
    chk({tag, "_feb"}, first_err_beat, 32'hFFFF_FFFF);
    chk({tag, "_fed"}, 32'(first_err_data), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    max_cycles  = 32'd0;
    throttle    = 4'd0;
    axis_tdata  = '0;
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    repeat (3) @(negedge clk);
    idle_check("reset");
    reset = 1'b0;
    @(negedge clk);
    idle_check("idle");

    // Clean 12-beat stream, no throttle.
    set_clean(12);
    run(32'd12, 4'd0, -1);
    axis_tvalid = 1'b0;
    final_check(32'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 16'h0000, 1'b1);
    chk("clean_cycles", 32'(run_cycles), 32'd12);

    // Beat 5 lane 7 corrupted; re-armed from DONE.
    set_clean(12);
    corr_beat = 5;
    corr_lane = 7;
    corr_val  = 16'hBEEF;
    run(32'd12, 4'd0, -1);
    axis_tvalid = 1'b0;
    final_check(32'd12, 32'd1, 32'd0, 32'd5, 16'h0005, 1'b0);

    // tlast missing on beat 3, present on beat 4.
    set_clean(8);
    for (int i = 0; i < 16; i++) lst[i] = 1'b0;
    lst[4] = 1'b1;
    run(32'd8, 4'd0, -1);
    axis_tvalid = 1'b0;
    final_check(32'd8, 32'd0, 32'd2, 32'd3, 16'h0000, 1'b0);

    // Throttle 3 with an always-valid source.
    set_clean(8);
    run(32'd8, 4'd3, -1);
    axis_tvalid = 1'b0;
    final_check(32'd8, 32'd0, 32'd0, 32'hFFFF_FFFF, 16'h0000, 1'b1);
    chk("throttle_cycles", 32'(run_cycles), 32'd29);

    // Counter wrap: stream starts at 0xFFFE.
    set_clean(4);
    dat[0] = 16'hFFFE;
    dat[1] = 16'hFFFF;
    dat[2] = 16'h0000;
    dat[3] = 16'h0001;
    run(32'd4, 4'd0, -1);
    axis_tvalid = 1'b0;
    final_check(32'd4, 32'd1, 32'd0, 32'd0, 16'hFFFE, 1'b0);

    // Reset after beat 2 with the source still valid; start during reset ignored.
    set_clean(12);
    run(32'd12, 4'd0, 3);
    reset = 1'b1;
    @(negedge clk);
    start      = 1'b1;
    max_cycles = 32'd5;
    @(negedge clk);
    start = 1'b0;
    idle_check("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    idle_check("post_reset");
    axis_tvalid = 1'b0;
    do_start(32'd0, 4'd0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_pass", 32'(pass), 32'd1);
    chk("zero_beats", beats_rcvd, 32'd0);
    chk("zero_tready", 32'(axis_tready), 32'd0);
    axis_tvalid = 1'b1;
    @(negedge clk);
    chk("zero_hold_beats", beats_rcvd, 32'd0);
    chk("zero_hold_done", 32'(done), 32'd1);
    axis_tvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
